// File: rtl/linebuf_fifo_fwft_if.sv
`default_nettype none
// ============================================================================
// Module   : linebuf_fifo_fwft_if
// Purpose  : Bundle of the FIFO write/read handshake, head-word output and
//            status flags used between a producer/consumer and
//            linebuf_fifo_fwft.
// Signals  : flush, we, di, re            (driven by the master)
//            dout, valid, empty_flag, full_flag, afull, aempty, count,
//            overflow, underflow          (driven by the FIFO / slave)
// Revision : 1.0 - initial release
// ============================================================================
interface linebuf_fifo_fwft_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 2048
);
    localparam int CW = $clog2(DEPTH + 2);

    logic          flush;
    logic          we;
    logic [DW-1:0] di;
    logic          re;
    logic [DW-1:0] dout;
    logic          valid;
    logic          empty_flag;
    logic          full_flag;
    logic          afull;
    logic          aempty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    modport master (
        output flush, we, di, re,
        input  dout, valid, empty_flag, full_flag, afull, aempty, count,
               overflow, underflow
    );

    modport slave (
        input  flush, we, di, re,
        output dout, valid, empty_flag, full_flag, afull, aempty, count,
               overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/linebuf_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : linebuf_fifo_fwft
// Purpose  : First-word-fall-through synchronous FIFO for the Sobel line
//            buffer. Simple dual-port RAM with registered read feeding a
//            one-word output register; the head word sits on dout whenever
//            valid is high. Total capacity is DEPTH+1 words.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous active-low reset
//            bus  - linebuf_fifo_fwft_if.slave (write/read handshake, head
//                   word, occupancy count and status/error flags)
// Revision : 1.0 - initial release
// ============================================================================
module linebuf_fifo_fwft #(
    parameter int DW        = 8,
    parameter int DEPTH     = 2048,
    parameter int AFULL_TH  = 1920,
    parameter int AEMPTY_TH = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    linebuf_fifo_fwft_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 2);

    localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);
    localparam logic [CW-1:0] C_AFULL_TH  = CW'(AFULL_TH);
    localparam logic [CW-1:0] C_AEMPTY_TH = CW'(AEMPTY_TH);
    localparam logic [AW-1:0] C_PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] C_CNT_ONE   = CW'(1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_rc;        // RAM occupancy, 0..DEPTH
    logic [DW-1:0] r_dout;
    logic          r_valid;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_wr;
    logic          w_rd;
    logic          w_ram_we;
    logic [CW-1:0] w_count;

    // Full is judged on current state only, so a pop in the same cycle does
    // not make room for a write.
    assign w_full   = (r_rc == C_DEPTH);
    assign w_wr     = bus.we && !w_full;
    // Refill the output register on a pop, or prefetch when it is empty.
    assign w_rd     = (r_rc != '0) && (bus.re || !r_valid);
    assign w_ram_we = rst && !bus.flush && w_wr;
    assign w_count  = r_rc + CW'(r_valid);

    // Storage array kept free of reset so it maps onto block RAM. A read
    // never targets the word being written: rc!=0 means rp points at older
    // data, and wp==rp with rc!=0 only when full, which blocks the write.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[r_wp] <= bus.di;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_rc        <= '0;
            r_dout      <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.flush) begin
            // dout deliberately keeps its last value.
            r_wp        <= '0;
            r_rp        <= '0;
            r_rc        <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + C_PTR_ONE;
            end

            if (w_rd) begin
                r_dout  <= r_mem[r_rp];
                r_rp    <= r_rp + C_PTR_ONE;
                r_valid <= 1'b1;
            end else if (bus.re && r_valid) begin
                r_valid <= 1'b0;
            end

            if (bus.we && w_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.re && !r_valid) begin
                r_underflow <= 1'b1;
            end

            case ({w_wr, w_rd})
                2'b10:   r_rc <= r_rc + C_CNT_ONE;
                2'b01:   r_rc <= r_rc - C_CNT_ONE;
                default: r_rc <= r_rc;
            endcase
        end
    end

    assign bus.dout       = r_dout;
    assign bus.valid      = r_valid;
    assign bus.empty_flag = ~r_valid;
    assign bus.full_flag  = w_full;
    assign bus.afull      = (r_rc >= C_AFULL_TH);
    assign bus.aempty     = (w_count <= C_AEMPTY_TH);
    assign bus.count      = w_count;
    assign bus.overflow   = r_overflow;
    assign bus.underflow  = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_linebuf_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : tb_linebuf_fifo_fwft
// Purpose  : Self-checking bench for linebuf_fifo_fwft (DW=8, DEPTH=16,
//            AFULL_TH=12, AEMPTY_TH=1). A queue-based reference model tracks
//            stored words, the output word and the sticky flags; a vector
//            table and directed sequences add explicit expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_linebuf_fifo_fwft;
    localparam int DW        = 8;
    localparam int DEPTH     = 16;
    localparam int AFULL_TH  = 12;
    localparam int AEMPTY_TH = 1;

    logic clk;
    logic rst;

    linebuf_fifo_fwft_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    linebuf_fifo_fwft #(
        .DW        (DW),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: words waiting behind the output register, plus the
    // output register itself.
    logic [DW-1:0] m_q [$];
    logic          m_valid;
    logic [DW-1:0] m_dout;
    logic          m_ovf;
    logic          m_unf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_tick(input logic r, input logic f, input logic w,
                              input logic [DW-1:0] d, input logic p);
        logic was_full;
        if (!r) begin
            m_q.delete();
            m_valid = 1'b0;
            m_dout  = '0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else if (f) begin
            m_q.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            was_full = (m_q.size() == DEPTH);
            if (p && !m_valid) m_unf = 1'b1;
            if (w && was_full) m_ovf = 1'b1;
            if (m_q.size() != 0 && (p || !m_valid)) begin
                m_dout  = m_q.pop_front();
                m_valid = 1'b1;
            end else if (p && m_valid) begin
                m_valid = 1'b0;
            end
            if (w && !was_full) m_q.push_back(d);
        end
    endtask

    task automatic check_model();
        int ec;
        ec = m_q.size() + int'(m_valid);
        chk("dout",      32'(bus.dout),       32'(m_dout));
        chk("valid",     32'(bus.valid),      32'(m_valid));
        chk("empty",     32'(bus.empty_flag), 32'(!m_valid));
        chk("full",      32'(bus.full_flag),  32'(m_q.size() == DEPTH));
        chk("afull",     32'(bus.afull),      32'(m_q.size() >= AFULL_TH));
        chk("aempty",    32'(bus.aempty),     32'(ec <= AEMPTY_TH));
        chk("count",     32'(bus.count),      32'(ec));
        chk("overflow",  32'(bus.overflow),   32'(m_ovf));
        chk("underflow", 32'(bus.underflow),  32'(m_unf));
    endtask

    // One clock: drive inputs, let the edge happen, advance the model,
    // then compare 1 ns after the edge.
    task automatic step(input logic r, input logic f, input logic w,
                        input logic [DW-1:0] d, input logic p);
        rst       = r;
        bus.flush = f;
        bus.we    = w;
        bus.di    = d;
        bus.re    = p;
        @(posedge clk);
        model_tick(r, f, w, d, p);
        #1;
        check_model();
    endtask

    typedef struct {
        logic          we;
        logic [DW-1:0] di;
        logic          re;
        logic          fl;
        logic          ev;
        logic [DW-1:0] ed;
        int            ec;
        logic          eu;
    } vec_t;

    vec_t tbl [12];

    initial begin
        //            we  di     re fl  valid dout  cnt unf
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 0, 1'b0};
        tbl[4]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'hA5, 1, 1'b0};
        tbl[5]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 2, 1'b0};
        tbl[6]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h22, 2, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 1, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h33, 0, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h33, 0, 1'b1};
        tbl[10] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 8'h33, 0, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h33, 0, 1'b0};

        m_valid = 1'b0;
        m_dout  = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;

        // Reset held 3 cycles with writes requested.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h5A + i), 1'b0);
        chk("rst_dout",   32'(bus.dout),       0);
        chk("rst_valid",  32'(bus.valid),      0);
        chk("rst_empty",  32'(bus.empty_flag), 1);
        chk("rst_full",   32'(bus.full_flag),  0);
        chk("rst_afull",  32'(bus.afull),      0);
        chk("rst_aempty", 32'(bus.aempty),     1);
        chk("rst_count",  32'(bus.count),      0);
        chk("rst_ovf",    32'(bus.overflow),   0);
        chk("rst_unf",    32'(bus.underflow),  0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_nothing_stored", 32'(bus.count), 0);

        // Table: fall-through latency, pop with/without refill, underflow, flush.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, tbl[i].fl, tbl[i].we, tbl[i].di, tbl[i].re);
            chk($sformatf("tbl%0d_valid", i), 32'(bus.valid),     32'(tbl[i].ev));
            chk($sformatf("tbl%0d_dout", i),  32'(bus.dout),      32'(tbl[i].ed));
            chk($sformatf("tbl%0d_count", i), 32'(bus.count),     32'(tbl[i].ec));
            chk($sformatf("tbl%0d_unf", i),   32'(bus.underflow), 32'(tbl[i].eu));
        end

        // Fill past capacity, then drain in order with no gaps.
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'(i), 1'b0);
            chk("fill_afull", 32'(bus.afull), 32'(i >= 12));
            if (i == 16) begin
                chk("fill_full",  32'(bus.full_flag), 1);
                chk("fill_count", 32'(bus.count),     17);
                chk("fill_ovf_before", 32'(bus.overflow), 0);
            end
        end
        chk("fill_ovf", 32'(bus.overflow), 1);
        chk("fill_count_after_reject", 32'(bus.count), 17);
        for (int k = 0; k < 17; k++) begin
            chk("drain_valid", 32'(bus.valid), 1);
            chk("drain_order", 32'(bus.dout),  32'(k));
            step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        end
        chk("drain_done_valid", 32'(bus.valid), 0);
        chk("drain_done_count", 32'(bus.count), 0);

        // Simultaneous pop and write while full.
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        chk("sf_full",  32'(bus.full_flag), 1);
        chk("sf_ovf0",  32'(bus.overflow),  0);
        step(1'b1, 1'b0, 1'b1, 8'h99, 1'b1);
        chk("sf_count", 32'(bus.count),    16);
        chk("sf_ovf",   32'(bus.overflow), 1);
        chk("sf_dout",  32'(bus.dout),     32'h0C1);

        // Streaming at half full: pointers wrap many times.
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'(i), 1'b1);
            chk("stream_count", 32'(bus.count), 8);
        end

        // Randomized traffic: write-heavy then read-heavy, rare flush/reset.
        for (int i = 0; i < 500; i++) begin
            logic w, p, f, r;
            w = ($urandom_range(0, 99) < ((i < 250) ? 80 : 30));
            p = ($urandom_range(0, 99) < ((i < 250) ? 30 : 80));
            f = ($urandom_range(0, 149) == 0);
            r = ($urandom_range(0, 249) != 0);
            step(r, f, w, 8'($urandom), p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/linebuf_fifo_fwft.md
# linebuf_fifo_fwft

Parametrised first-word-fall-through synchronous FIFO for the Sobel line buffer, the generalised successor to the fixed 2048x8 look-ahead FIFO. It owns its storage (inferred simple dual-port RAM with registered read) plus a one-word output register. The head word is always presented on `dout` qualified by `valid`. It adds a configurable width, depth and almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags.

## Interface
- `DW`, 8, data width in bits
- `DEPTH`, 2048, RAM depth in words; power of two, >= 4
- `AFULL_TH`, 1920, `afull` asserts when RAM occupancy >= this value; 1..DEPTH
- `AEMPTY_TH`, 1, `aempty` asserts when total occupancy <= this value
- `CW`, $clog2(DEPTH+2), count width (derived, not overridden)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-low reset
- `flush`  in  1  synchronous clear of contents and error flags
- `we`  in  1  write strobe
- `di`  in  DW  write data
- `re`  in  1  pop the word currently on `dout`
- `dout`  out  DW  head word, registered
- `valid`  out  1  `dout` holds a valid word
- `empty_flag`  out  1  equals ~`valid`
- `full_flag`  out  1  RAM occupancy == DEPTH
- `afull`  out  1  RAM occupancy >= AFULL_TH
- `aempty`  out  1  `count` <= AEMPTY_TH
- `count`  out  CW  RAM occupancy + `valid`, range 0..DEPTH+1
- `overflow`  out  1  sticky: a write was rejected
- `underflow`  out  1  sticky: `re` was asserted while `valid`=0

## Operation
- Storage: write pointer `wp`, read pointer `rp`, `log2(DEPTH)` bits each, wrapping modulo DEPTH. RAM occupancy `rc` ranges 0..DEPTH.
- Write accepted: `we` && !`full_flag`. `di` is written at `wp`, and `wp` advances. If `we` is asserted while full, the write is dropped and `overflow` is set. `full_flag` is evaluated on the current state, so a write in the same cycle as a pop-while-full is still rejected.
- Internal RAM read: `rd` = (`rc`!=0) && (`re` || !`valid`). This covers a normal pop with refill and a prefetch into an empty output stage. On `rd`, RAM[`rp`] is loaded into `dout`, `rp` advances, and `valid` is set to 1.
- Pop without refill: `re` && `valid` && `rc`==0 clears `valid`. `dout` holds its last value.
- `re` while `valid`=0: no effect on data; sets `underflow`.
- `rc` update: +1 on an accepted write, -1 on `rd`. Both in the same cycle leaves it unchanged.
- `count` = `rc` + `valid`. All flags are combinational from registered state, so there is no flag lag.
- Priority: `rst` low > `flush` high > normal operation. During flush, `we`/`re` are ignored. Flush zeroes `wp`, `rp`, `rc`, `valid`, `overflow` and `underflow`. `dout` keeps its value.
- Reset values: `dout`=0, `valid`=0, `empty_flag`=1, `full_flag`=0, `afull`=0, `aempty`=1 (for AEMPTY_TH>=0), `count`=0, `overflow`=0, `underflow`=0. Reset mid-operation discards all contents with no partial state.

## Timing
- Write-to-output latency on an empty FIFO is 2 cycles. A write sampled at edge E0 makes `rc`=1, `rd` is asserted in the next cycle, and at E1 `dout` is loaded and `valid` goes high (visible in cycle 2 relative to the write cycle 0).
- Sustained `we`+`re` with `valid`=1 and `rc`>=1 gives one word per cycle with no bubbles; `dout` updates at the same edge that consumes `re`.
- `full_flag` rises the cycle after the DEPTH-th RAM write. Total capacity is DEPTH+1 words (RAM plus the output register).
- `afull`, `aempty` and `count` are valid in the same cycle as the state they describe.
- The RAM must be inferred with a registered read port. There is no combinational path from `we`/`di` to `dout`.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `we`=1 → all outputs at their reset values, `count`=0, nothing stored.
- Fall-through: write 0xA5 in cycle 0 only → `valid`=1 and `dout`=0xA5 in cycle 2; `re` in cycle 3 → `valid`=0, `count`=0 in cycle 4, `underflow` still 0.
- Fill and overflow (DEPTH=16, AFULL_TH=12): write 0..17 back-to-back with no reads → `afull` rises after the 13th accepted write, `full_flag`=1 with `count`=17, write of 17 rejected and `overflow`=1; then drain reads 0..16 in order, with no gaps after the first.
- Streaming: simultaneous `we`/`re` for 100 cycles at half-full → `count` is constant, output order matches input order, and `wp`/`rp` wrap at 16 without data loss.
- Underflow and flush: `re`=1 while empty → `underflow`=1; then load 5 words and pulse `flush` with `we`=1 → next cycle `count`=0, `valid`=0, `underflow`=0, and the flush-cycle write is dropped.
- Simultaneous full: with `full_flag`=1, assert `we`+`re` → pop occurs, write rejected, `overflow`=1, `count` drops by 1.
